// File: rtl/banded_sw_accelerator.sv
// Banded Smith-Waterman aligner: 8-base reference vs 8-base query over a 4-diagonal band.
// Fills the score/traceback band row by row, tracks the best cell, then traces back into gapped strings.
module banded_sw_accelerator (
    input  logic        clk,
    input  logic        start,
    input  logic [23:0] R,
    input  logic [23:0] Q,
    output logic [29:0] R_aligned,
    output logic [29:0] Q_aligned,
    output logic        ready,
    output logic [95:0] pe_mem1,
    output logic [95:0] pe_mem2,
    output logic [95:0] pe_mem3,
    output logic [95:0] pe_mem4
);
    // state  | meaning
    // IDLE   | after reset, waits one edge
    // LOAD   | latch R/Q, clear band state
    // FILL   | compute row `row` for all four diagonals
    // MAX    | seed traceback from best cell (empty if best is 0)
    // TRACE  | emit one aligned symbol pair per cycle, walking back
    // DONE   | results held, ready high
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_MAX   = 3'd3;
    localparam logic [2:0] S_TRACE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int NPE    = 4;
    localparam int ALNLEN = 10;
    localparam logic signed [11:0] MATCH    = 12'sd2;
    localparam logic signed [11:0] MISMATCH = -12'sd1;
    localparam logic signed [11:0] GAP      = -12'sd1;
    localparam logic [2:0] SYM_GAP = 3'b100;

    logic [2:0]             state;
    logic [23:0]            r_q, q_q;
    logic [2:0]             row;
    logic [NPE-1:0][9:0]    h_prev;
    logic [NPE-1:0][95:0]   mem;
    logic [9:0]             max_h;
    logic [2:0]             max_i;
    logic [1:0]             max_p;
    logic [3:0]             ti;
    logic [1:0]             tp;
    logic [3:0]             n_sym;

    logic [NPE:0][9:0]      h_up;
    logic [NPE-1:0][9:0]    h_cur;
    logic [NPE-1:0][1:0]    ptr_cur;
    logic [2:0]             qb, rb;
    logic [4:0]             jj;
    logic                   match;
    logic signed [11:0]     v_diag, v_up, v_left, v_m;
    logic [9:0]             left_h;
    logic [9:0]             mx_h;
    logic [2:0]             mx_i;
    logic [1:0]             mx_p;

    // PE p+1 of the previous row supplies the "up" neighbour; beyond the band it reads 0.
    assign h_up = {10'd0, h_prev};

    always_comb begin
        qb      = q_q[3*row +: 3];
        rb      = '0;
        jj      = '0;
        match   = 1'b0;
        v_diag  = '0;
        v_up    = '0;
        v_left  = '0;
        v_m     = '0;
        left_h  = '0;
        h_cur   = '0;
        ptr_cur = '0;
        mx_h    = max_h;
        mx_i    = max_i;
        mx_p    = max_p;
        for (int p = 0; p < NPE; p++) begin
            // j = row + p - 1; a wrap to 31 marks j = -1 as out of range
            jj     = 5'(row) + 5'(p) - 5'd1;
            rb     = r_q[3*jj[2:0] +: 3];
            match  = !qb[2] && (qb == rb);
            v_diag = $signed({2'b00, h_prev[p]}) + (match ? MATCH : MISMATCH);
            v_up   = $signed({2'b00, h_up[p+1]}) + GAP;
            v_left = $signed({2'b00, left_h}) + GAP;
            v_m    = 12'sd0;
            if (v_diag > v_m) v_m = v_diag;
            if (v_up > v_m)   v_m = v_up;
            if (v_left > v_m) v_m = v_left;
            if (jj < 5'd8) begin
                h_cur[p] = v_m[9:0];
                if (v_m == 12'sd0)        ptr_cur[p] = 2'b00;
                else if (v_m == v_diag)   ptr_cur[p] = 2'b01;
                else if (v_m == v_up)     ptr_cur[p] = 2'b10;
                else                      ptr_cur[p] = 2'b11;
            end
            left_h = h_cur[p];
            if (h_cur[p] > mx_h) begin
                mx_h = h_cur[p];
                mx_i = row;
                mx_p = 2'(p);
            end
        end
    end

    logic [11:0] t_entry;
    logic [2:0]  tj;
    logic [2:0]  t_rsym, t_qsym;
    logic        t_stop;

    assign t_entry = mem[tp][12*ti[2:0] +: 12];
    assign tj      = ti[2:0] + {1'b0, tp} - 3'd1;
    assign t_rsym  = r_q[3*tj +: 3];
    assign t_qsym  = q_q[3*ti[2:0] +: 3];
    assign t_stop  = ti[3] || (t_entry[11:10] == 2'b00) || (t_entry[9:0] == 10'd0)
                     || (n_sym == 4'(ALNLEN));

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state     <= S_IDLE;
            r_q       <= '0;
            q_q       <= '0;
            row       <= '0;
            h_prev    <= '0;
            mem       <= '0;
            max_h     <= '0;
            max_i     <= '0;
            max_p     <= '0;
            ti        <= '0;
            tp        <= '0;
            n_sym     <= '0;
            R_aligned <= '1;
            Q_aligned <= '1;
            ready     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_LOAD;
                S_LOAD: begin
                    r_q    <= R;
                    q_q    <= Q;
                    row    <= '0;
                    h_prev <= '0;
                    max_h  <= '0;
                    state  <= S_FILL;
                end
                S_FILL: begin
                    for (int p = 0; p < NPE; p++)
                        mem[p][12*row +: 12] <= {ptr_cur[p], h_cur[p]};
                    h_prev <= h_cur;
                    max_h  <= mx_h;
                    max_i  <= mx_i;
                    max_p  <= mx_p;
                    if (row == 3'd7) state <= S_MAX;
                    else             row   <= row + 3'd1;
                end
                S_MAX: begin
                    ti    <= {1'b0, max_i};
                    tp    <= max_p;
                    n_sym <= '0;
                    if (max_h == 10'd0) begin
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_TRACE;
                    end
                end
                S_TRACE: begin
                    if (t_stop) begin
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        // symbols arrive last-to-first; shifting in at slot 0 leaves them in forward order
                        n_sym <= n_sym + 4'd1;
                        case (t_entry[11:10])
                            2'b01: begin
                                R_aligned <= {t_rsym, R_aligned[29:3]};
                                Q_aligned <= {t_qsym, Q_aligned[29:3]};
                                ti        <= ti - 4'd1;
                            end
                            2'b10: begin
                                R_aligned <= {SYM_GAP, R_aligned[29:3]};
                                Q_aligned <= {t_qsym, Q_aligned[29:3]};
                                ti        <= ti - 4'd1;
                                tp        <= tp + 2'd1;
                            end
                            default: begin
                                R_aligned <= {t_rsym, R_aligned[29:3]};
                                Q_aligned <= {SYM_GAP, Q_aligned[29:3]};
                                tp        <= tp - 2'd1;
                            end
                        endcase
                    end
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pe_mem1 = mem[0];
    assign pe_mem2 = mem[1];
    assign pe_mem3 = mem[2];
    assign pe_mem4 = mem[3];
endmodule

// File: tb/tb_banded_sw_accelerator.sv
// Directed bench for banded_sw_accelerator: expected alignments queued per run, compared when ready rises.
module tb_banded_sw_accelerator;
    logic        clk;
    logic        start;
    logic [23:0] R, Q;
    logic [29:0] R_aligned, Q_aligned;
    logic        ready;
    logic [95:0] pe_mem1, pe_mem2, pe_mem3, pe_mem4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] r_al;
        logic [29:0] q_al;
    } exp_t;
    exp_t sb[$];

    banded_sw_accelerator dut (
        .clk       (clk),
        .start     (start),
        .R         (R),
        .Q         (Q),
        .R_aligned (R_aligned),
        .Q_aligned (Q_aligned),
        .ready     (ready),
        .pe_mem1   (pe_mem1),
        .pe_mem2   (pe_mem2),
        .pe_mem3   (pe_mem3),
        .pe_mem4   (pe_mem4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] code(input byte c);
        case (c)
            "A":     return 3'b000;
            "C":     return 3'b001;
            "G":     return 3'b010;
            "T":     return 3'b011;
            "-":     return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [23:0] seq(input string s);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[3*k +: 3] = code(s[k]);
        return v;
    endfunction

    function automatic logic [29:0] aln(input string s);
        logic [29:0] v;
        v = '1;
        for (int k = 0; k < 10; k++) v[29-3*k -: 3] = code(s[k]);
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_ready"}, 96'(ready), 96'(1'b0));
        check({tag, "_r_aligned"}, 96'(R_aligned), 96'(30'h3FFFFFFF));
        check({tag, "_q_aligned"}, 96'(Q_aligned), 96'(30'h3FFFFFFF));
        check({tag, "_pe_mem1"}, pe_mem1, 96'd0);
        check({tag, "_pe_mem2"}, pe_mem2, 96'd0);
        check({tag, "_pe_mem3"}, pe_mem3, 96'd0);
        check({tag, "_pe_mem4"}, pe_mem4, 96'd0);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic wait_ready_and_score(input string tag);
        exp_t e;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready) break;
        end
        check({tag, "_ready_within_40"}, 96'(ready), 96'(1'b1));
        e = sb.pop_front();
        check({tag, "_r_aligned"}, 96'(R_aligned), 96'(e.r_al));
        check({tag, "_q_aligned"}, 96'(Q_aligned), 96'(e.q_al));
    endtask

    task automatic check_identity_band(input string tag);
        for (int i = 0; i < 8; i++)
            check({tag, "_pe_mem2_row"}, 96'(pe_mem2[12*i +: 12]), 96'({2'b01, 10'(2*(i+1))}));
    endtask

    initial begin
        exp_t e;
        start = 1'b0;
        R = '0;
        Q = '0;
        #13;
        apply_reset("por");

        // identical sequences: full diagonal match
        R = seq("ACGTACGT");
        Q = seq("ACGTACGT");
        e.r_al = aln("ACGTACGT");
        e.q_al = aln("ACGTACGT");
        sb.push_back(e);
        release_start();
        wait_ready_and_score("ident");
        check_identity_band("ident");

        // one-base deletion in the query
        apply_reset("rst2");
        R = seq("ACGTACGT");
        Q = seq("ACGACGTA");
        e.r_al = aln("ACGTACGT");
        e.q_al = aln("ACG-ACGT");
        sb.push_back(e);
        release_start();
        wait_ready_and_score("gap");
        check("gap_pe_mem3_row6", 96'(pe_mem3[83:72]), 96'({2'b01, 10'd13}));

        // nothing matches: empty alignment
        apply_reset("rst3");
        R = seq("AAAAAAAA");
        Q = seq("CCCCCCCC");
        e.r_al = 30'h3FFFFFFF;
        e.q_al = 30'h3FFFFFFF;
        sb.push_back(e);
        release_start();
        wait_ready_and_score("nomatch");
        check("nomatch_pe_mem1", pe_mem1, 96'd0);
        check("nomatch_pe_mem2", pe_mem2, 96'd0);
        check("nomatch_pe_mem3", pe_mem3, 96'd0);
        check("nomatch_pe_mem4", pe_mem4, 96'd0);

        // reset asserted in the middle of FILL, then a clean rerun
        apply_reset("rst4");
        R = seq("ACGTACGT");
        Q = seq("ACGTACGT");
        release_start();
        repeat (7) @(posedge clk);
        apply_reset("midfill");
        e.r_al = aln("ACGTACGT");
        e.q_al = aln("ACGTACGT");
        sb.push_back(e);
        release_start();
        wait_ready_and_score("rerun");
        check_identity_band("rerun");

        // inputs change after LOAD; latched values must win
        apply_reset("rst5");
        R = seq("ACGTACGT");
        Q = seq("ACGACGTA");
        e.r_al = aln("ACGTACGT");
        e.q_al = aln("ACG-ACGT");
        sb.push_back(e);
        release_start();
        repeat (3) @(posedge clk);
        #1;
        R = seq("AAAAAAAA");
        Q = seq("CCCCCCCC");
        wait_ready_and_score("latch");

        // long hold in DONE
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c % 100 == 0) begin
                check("hold_ready", 96'(ready), 96'(1'b1));
                check("hold_r_aligned", 96'(R_aligned), 96'(aln("ACGTACGT")));
                check("hold_q_aligned", 96'(Q_aligned), 96'(aln("ACG-ACGT")));
                check("hold_pe_mem3_row6", 96'(pe_mem3[83:72]), 96'({2'b01, 10'd13}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
